// File: rtl/turn_pkg.sv
// Shared turn-signal definitions: direction codes and lever FSM states.
// Used by the lever conditioner and the lamp sequencer.
package turn_pkg;

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_R   = 2'b01;
    localparam logic [1:0] DIR_L   = 2'b10;

    typedef enum logic [1:0] {
        OFF,
        LEFT,
        RIGHT,
        BOTH
    } state_e;

endpackage

// File: rtl/sw_debounce.sv
// One lever switch: 2-flop synchroniser followed by a counting debouncer.
// The stable output only flips after DEB_LEN consecutive differing samples.
module sw_debounce #(
    parameter int DEB_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_stable
);

    localparam int CW = $clog2(DEB_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/turn_lever_cond.sv
// Turn lever conditioner: debounced left/right -> direction code D and step strobe TICK.
// FIRST_WINS_EN: when both levers are on, hold the direction that was active on entry.
module turn_lever_cond
    import turn_pkg::*;
#(
    parameter int DEB_LEN  = 4,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       L_SW,
    input  logic       R_SW,
    output logic [1:0] D,
    output logic       TICK
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

    logic          w_l;
    logic          w_r;
    state_e        r_state;
    state_e        w_next;
    logic [1:0]    r_d;
    logic [1:0]    w_d_next;
    logic          w_restart;
    logic [DW-1:0] r_div;
    logic          r_tick;

    sw_debounce #(.DEB_LEN(DEB_LEN)) u_deb_l (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_sw    (L_SW),
        .o_stable(w_l)
    );

    sw_debounce #(.DEB_LEN(DEB_LEN)) u_deb_r (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_sw    (R_SW),
        .o_stable(w_r)
    );

    always_comb begin
        w_next   = OFF;
        w_d_next = DIR_OFF;
        unique case ({w_l, w_r})
            2'b10:   w_next = LEFT;
            2'b01:   w_next = RIGHT;
            2'b11:   w_next = BOTH;
            default: w_next = OFF;
        endcase
        unique case (w_next)
            LEFT:    w_d_next = DIR_L;
            RIGHT:   w_d_next = DIR_R;
            BOTH: begin
`ifdef FIRST_WINS_EN
                w_d_next = r_d;
`else
                w_d_next = DIR_OFF;
`endif
            end
            default: w_d_next = DIR_OFF;
        endcase
        // D can only move on a state transition; a new active code restarts pacing
        w_restart = (w_next != r_state) && (w_d_next != r_d)
                    && (w_d_next != DIR_OFF);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= OFF;
            r_d     <= DIR_OFF;
            r_div   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_d     <= w_d_next;
            if (w_d_next == DIR_OFF) begin
                r_div  <= '0;
                r_tick <= 1'b0;
            end else if (w_restart) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else if (r_div == DIV_MAX) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + 1'b1;
                r_tick <= 1'b0;
            end
        end
    end

    assign D    = r_d;
    assign TICK = r_tick;

endmodule

// File: tb/tb_turn_lever_cond.sv
// Directed bench for turn_lever_cond (DEB_LEN=4, TICK_DIV=8).
// Vectors: set levers, advance N edges, compare D/TICK 1 time unit after the edge.
module tb_turn_lever_cond;

    logic       CLK;
    logic       RST_N;
    logic       L_SW;
    logic       R_SW;
    logic [1:0] D;
    logic       TICK;

    int errors = 0;
    int checks = 0;

    turn_lever_cond #(.DEB_LEN(4), .TICK_DIV(8)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .L_SW (L_SW),
        .R_SW (R_SW),
        .D    (D),
        .TICK (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic       l;
        logic       r;
        logic [1:0] d;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

`ifdef FIRST_WINS_EN
    localparam logic [1:0] D_CONF = 2'b10;
    localparam logic       T_CONF = 1'b1;
`else
    localparam logic [1:0] D_CONF = 2'b00;
    localparam logic       T_CONF = 1'b0;
`endif

    task automatic check(input string name, input logic [1:0] ed,
                         input logic et);
        checks++;
        if (D !== ed || TICK !== et) begin
            errors++;
            $display("FAIL %s: got D=%b TICK=%b, want D=%b TICK=%b",
                     name, D, TICK, ed, et);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic add(input int c, input logic l, input logic r,
                       input logic [1:0] d, input logic t);
        vec_t v;
        v.cyc  = c;
        v.l    = l;
        v.r    = r;
        v.d    = d;
        v.tick = t;
        vecs.push_back(v);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            L_SW = vecs[i].l;
            R_SW = vecs[i].r;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].tick);
        end
    endtask

    initial begin
        int n_a;
        // Power-up, left held, divider cadence
        add(6, 1, 0, 2'b00, 0);
        add(1, 1, 0, 2'b10, 1);
        add(1, 1, 0, 2'b10, 0);
        add(6, 1, 0, 2'b10, 0);
        add(1, 1, 0, 2'b10, 1);
        add(7, 1, 0, 2'b10, 0);
        add(1, 1, 0, 2'b10, 1);
        add(8, 1, 0, 2'b10, 1);
        // Direct left -> right swap
        add(6, 0, 1, 2'b10, 0);
        add(1, 0, 1, 2'b01, 1);
        add(1, 0, 1, 2'b01, 0);
        add(6, 0, 1, 2'b01, 0);
        add(1, 0, 1, 2'b01, 1);
        n_a = vecs.size();
        // Right release
        add(6, 0, 0, 2'b01, 0);
        add(1, 0, 0, 2'b00, 0);
        add(1, 0, 0, 2'b00, 0);
        add(8, 0, 0, 2'b00, 0);
        // Bounce on right, never accepted
        add(3, 0, 1, 2'b00, 0);
        add(2, 0, 0, 2'b00, 0);
        add(3, 0, 1, 2'b00, 0);
        add(10, 0, 0, 2'b00, 0);
        // Conflict: left steady, right joins
        add(7, 1, 0, 2'b10, 1);
        add(8, 1, 0, 2'b10, 1);
        add(7, 1, 1, D_CONF, 0);
        add(1, 1, 1, D_CONF, T_CONF);
        add(8, 1, 1, D_CONF, T_CONF);
        add(7, 0, 0, 2'b00, 0);
        add(1, 0, 0, 2'b00, 0);
        // Clean left on, then release
        add(7, 1, 0, 2'b10, 1);
        add(6, 0, 0, 2'b10, 0);
        add(1, 0, 0, 2'b00, 0);

        RST_N = 1'b0;
        L_SW  = 1'b1;
        R_SW  = 1'b0;
        #2;
        check("reset_async", 2'b00, 1'b0);
        step(3);
        check("reset_held", 2'b00, 1'b0);
        RST_N = 1'b1;

        run(0, n_a);

        // Asynchronous reset with divider mid-count
        step(5);
        check("pre_reset_div5", 2'b01, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        check("mid_reset", 2'b00, 1'b0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        step(6);
        check("post_reset_e6", 2'b00, 1'b0);
        step(1);
        check("post_reset_e7", 2'b01, 1'b1);

        run(n_a, vecs.size());

        for (int i = 0; i < 12; i++) begin
            step(1);
            check($sformatf("off_quiet%0d", i), 2'b00, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
